mem_copy_engine: RTL and testbench

Memory-side initiator that drives the single-port data memory's write/read interface to copy a block of bytes from a source address range to a destination range. It is the master end of the `memWrite`/`memRead`/`addressMem`/`dataMem`/`wordRegIn` interface and sits between the controller, which issues `start` with a descriptor, and the data memory. Each byte is moved in one read cycle followed by one write cycle, and `done` pulses when the whole block has been copied.

---
 rtl/mem_copy_pkg.sv | 14 +
 rtl/mem_copy_engine.sv | 143 ++++++++++++++
 tb/tb_mem_copy_engine.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_copy_pkg.sv
// Shared definitions for the memory copy engine: default widths and the FSM state type.
package mem_copy_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } copyState_t;

endpackage

// File: rtl/mem_copy_engine.sv
// Block copy engine driving a single-port data memory: one READ then one WRITE per byte.
// Optional fill mode (one WRITE per byte of a latched value) is enabled by defining MEM_COPY_FILL_EN.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] srcAddr,
  input  logic [ADDR_W-1:0] dstAddr,
  input  logic [ADDR_W-1:0] length,
  input  logic              fillMode,
  input  logic [DATA_W-1:0] fillValue,
  output logic              busy,
  output logic              done,
  output logic              memWrite,
  output logic              memRead,
  output logic [ADDR_W-1:0] addressMem,
  output logic [DATA_W-1:0] dataMem,
  input  logic [DATA_W-1:0] wordRegIn
);

  copyState_t state, nextState;

  logic [ADDR_W-1:0] srcPtr;
  logic [ADDR_W-1:0] dstPtr;
  logic [ADDR_W-1:0] remaining;
  logic [DATA_W-1:0] buffer;

`ifdef MEM_COPY_FILL_EN
  logic fillActive;
`else
  logic unusedFill;
  assign unusedFill = ^{fillMode, fillValue};
`endif

  // State register plus the datapath registers updated per state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      srcPtr    <= '0;
      dstPtr    <= '0;
      remaining <= '0;
      buffer    <= '0;
`ifdef MEM_COPY_FILL_EN
      fillActive <= 1'b0;
`endif
    end else begin
      state <= nextState;
      case (state)
        IDLE: begin
          if (start) begin
            srcPtr    <= srcAddr;
            dstPtr    <= dstAddr;
            remaining <= length;
`ifdef MEM_COPY_FILL_EN
            fillActive <= fillMode;
            if (fillMode) begin
              buffer <= fillValue;
            end
`endif
          end
        end
        READ: begin
          buffer <= wordRegIn;
        end
        WRITE: begin
          srcPtr    <= srcPtr + ADDR_W'(1);
          dstPtr    <= dstPtr + ADDR_W'(1);
          remaining <= remaining - ADDR_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state logic; remaining still holds the pre-decrement count during WRITE.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (length == '0) begin
            nextState = DONE;
          end else begin
`ifdef MEM_COPY_FILL_EN
            nextState = fillMode ? WRITE : READ;
`else
            nextState = READ;
`endif
          end
        end
      end
      READ:  nextState = WRITE;
      WRITE: begin
        if (remaining == ADDR_W'(1)) begin
          nextState = DONE;
        end else begin
`ifdef MEM_COPY_FILL_EN
          nextState = fillActive ? WRITE : READ;
`else
          nextState = READ;
`endif
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Moore outputs decoded from the registered state only.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    memWrite   = 1'b0;
    memRead    = 1'b0;
    addressMem = '0;
    dataMem    = '0;
    case (state)
      READ: begin
        busy       = 1'b1;
        memRead    = 1'b1;
        addressMem = srcPtr;
      end
      WRITE: begin
        busy       = 1'b1;
        memWrite   = 1'b1;
        addressMem = dstPtr;
        dataMem    = buffer;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine against a byte-array memory model.
// Fill expectations follow MEM_COPY_FILL_EN when it is defined.
module tb_mem_copy_engine;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] srcAddr, dstAddr, length;
  logic       fillMode;
  logic [7:0] fillValue;
  logic       busy, done, memWrite, memRead;
  logic [7:0] addressMem, dataMem, wordRegIn;

  logic [7:0] mem    [256];
  logic [7:0] refMem [256];
  logic       pokeEn;
  logic [7:0] pokeAddr, pokeData;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clock = ~clock;

  mem_copy_engine #(.ADDR_W(8), .DATA_W(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .srcAddr    (srcAddr),
    .dstAddr    (dstAddr),
    .length     (length),
    .fillMode   (fillMode),
    .fillValue  (fillValue),
    .busy       (busy),
    .done       (done),
    .memWrite   (memWrite),
    .memRead    (memRead),
    .addressMem (addressMem),
    .dataMem    (dataMem),
    .wordRegIn  (wordRegIn)
  );

  // Data memory: DUT writes take priority over bench preloads.
  always @(posedge clock) begin
    if (memWrite) mem[addressMem] <= dataMem;
    else if (pokeEn) mem[pokeAddr] <= pokeData;
  end

  assign wordRegIn = mem[addressMem];

  task automatic pokeByte(input logic [7:0] a, input logic [7:0] d);
    @(negedge clock);
    pokeEn   = 1'b1;
    pokeAddr = a;
    pokeData = d;
    @(posedge clock);
    #1;
    pokeEn    = 1'b0;
    refMem[a] = d;
  endtask

  // Presents a descriptor for one edge, then scrambles the inputs to prove they were latched.
  task automatic applyStimulus(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                               input logic fm, input logic [7:0] fv);
    @(negedge clock);
    start     = 1'b1;
    srcAddr   = s;
    dstAddr   = d;
    length    = l;
    fillMode  = fm;
    fillValue = fv;
    @(posedge clock);
    #1;
    start     = 1'b0;
    srcAddr   = 8'($urandom);
    dstAddr   = 8'($urandom);
    length    = 8'($urandom);
    fillMode  = 1'($urandom);
    fillValue = 8'($urandom);
  endtask

  task automatic runTransfer(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                             input logic fm, input logic [7:0] fv, input bit midStart,
                             input string name);
    int  n, expDone, expBusy, expReads;
    int  cyc, doneCyc, busyN, readN, writeN, firstBad;
    bit  fillOn, bothBad, idleBad;
    n = int'(l);
`ifdef MEM_COPY_FILL_EN
    fillOn = fm;
`else
    fillOn = 1'b0;
`endif
    for (int i = 0; i < n; i++) begin
      logic [7:0] sa, da;
      sa = 8'(int'(s) + i);
      da = 8'(int'(d) + i);
      refMem[da] = fillOn ? fv : refMem[sa];
    end
    expDone  = (n == 0) ? 1 : (fillOn ? n + 1 : 2 * n + 1);
    expBusy  = (n == 0) ? 0 : (fillOn ? n : 2 * n);
    expReads = fillOn ? 0 : n;

    applyStimulus(s, d, l, fm, fv);
    cyc = 0; doneCyc = 0; busyN = 0; readN = 0; writeN = 0;
    bothBad = 1'b0; idleBad = 1'b0;
    while (doneCyc == 0 && cyc < 600) begin
      @(negedge clock);
      cyc++;
      if (busy) busyN++;
      if (memRead) readN++;
      if (memWrite) writeN++;
      if (memRead && memWrite) bothBad = 1'b1;
      if (!busy && (memRead || memWrite || addressMem != 8'h00 || dataMem != 8'h00)) idleBad = 1'b1;
      if (midStart && cyc == 3) begin
        start    = 1'b1;
        srcAddr  = 8'($urandom);
        dstAddr  = 8'($urandom);
        length   = 8'($urandom_range(1, 255));
        fillMode = 1'($urandom);
      end
      if (cyc == 4) start = 1'b0;
      if (done) doneCyc = cyc;
    end
    @(negedge clock);

    checkCount++;
    if (doneCyc !== expDone) $display("[TB] FAIL %s doneCycle: got %0d expected %0d", name, doneCyc, expDone);
    else passCount++;
    checkCount++;
    if (busyN !== expBusy) $display("[TB] FAIL %s busyCycles: got %0d expected %0d", name, busyN, expBusy);
    else passCount++;
    checkCount++;
    if (readN !== expReads) $display("[TB] FAIL %s readCycles: got %0d expected %0d", name, readN, expReads);
    else passCount++;
    checkCount++;
    if (writeN !== n) $display("[TB] FAIL %s writeCycles: got %0d expected %0d", name, writeN, n);
    else passCount++;
    checkCount++;
    if (bothBad !== 1'b0) $display("[TB] FAIL %s strobeOverlap: got %0b expected 0", name, bothBad);
    else passCount++;
    checkCount++;
    if (idleBad !== 1'b0) $display("[TB] FAIL %s idleOutputs: got %0b expected 0", name, idleBad);
    else passCount++;
    checkCount++;
    if ({done, busy} !== 2'b00) $display("[TB] FAIL %s donePulse: got done=%0b busy=%0b expected 0 0", name, done, busy);
    else passCount++;
    firstBad = -1;
    for (int a = 0; a < 256; a++) begin
      if (firstBad < 0 && mem[a] !== refMem[a]) firstBad = a;
    end
    checkCount++;
    if (firstBad >= 0)
      $display("[TB] FAIL %s memory[%0h]: got %0h expected %0h", name, firstBad, mem[firstBad], refMem[firstBad]);
    else passCount++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkCount++;
    if ({busy, done, memWrite, memRead, addressMem, dataMem} !== 20'h0)
      $display("[TB] FAIL resetOutputs: got %0h expected 0", {busy, done, memWrite, memRead, addressMem, dataMem});
    else passCount++;
    for (int a = 0; a < 256; a++) pokeByte(8'(a), 8'($urandom));
    reset = 1'b0;
  endtask

  task automatic test_copy();
    pokeByte(8'h10, 8'hA1);
    pokeByte(8'h11, 8'hB2);
    pokeByte(8'h12, 8'hC3);
    pokeByte(8'h13, 8'hD4);
    runTransfer(8'h10, 8'h80, 8'd4, 1'b0, 8'h00, 1'b0, "copy4");
  endtask

  task automatic test_zero_length();
    runTransfer(8'h33, 8'h44, 8'd0, 1'b0, 8'h00, 1'b0, "zeroLen");
  endtask

  task automatic test_wrap();
    pokeByte(8'hFE, 8'h11);
    pokeByte(8'hFF, 8'h22);
    pokeByte(8'h00, 8'h33);
    runTransfer(8'hFE, 8'h01, 8'd3, 1'b0, 8'h00, 1'b0, "wrap");
  endtask

  task automatic test_mid_reset();
    int firstBad;
    applyStimulus(8'h40, 8'h90, 8'd4, 1'b0, 8'h00);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkCount++;
    if ({busy, done, memWrite, memRead, addressMem, dataMem} !== 20'h0)
      $display("[TB] FAIL midResetOutputs: got %0h expected 0", {busy, done, memWrite, memRead, addressMem, dataMem});
    else passCount++;
    reset = 1'b0;
    refMem[8'h90] = refMem[8'h40];
    refMem[8'h91] = refMem[8'h41];
    @(negedge clock);
    firstBad = -1;
    for (int a = 0; a < 256; a++) begin
      if (firstBad < 0 && mem[a] !== refMem[a]) firstBad = a;
    end
    checkCount++;
    if (firstBad >= 0)
      $display("[TB] FAIL midResetMemory[%0h]: got %0h expected %0h", firstBad, mem[firstBad], refMem[firstBad]);
    else passCount++;
    runTransfer(8'h40, 8'hC0, 8'd4, 1'b0, 8'h00, 1'b0, "afterReset");
  endtask

  task automatic test_ignore_start();
    runTransfer(8'h50, 8'hA0, 8'd6, 1'b0, 8'h00, 1'b1, "ignoreStart");
  endtask

  task automatic test_fill();
    runTransfer(8'h00, 8'h20, 8'd5, 1'b1, 8'h5A, 1'b0, "fill");
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      logic [7:0] l;
      bit         mid;
      l   = 8'($urandom_range(0, 24));
      mid = (l >= 8'd3) && ($urandom_range(0, 1) == 1);
      runTransfer(8'($urandom), 8'($urandom), l, 1'($urandom), 8'($urandom), mid, $sformatf("random%0d", k));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; srcAddr = 8'h00; dstAddr = 8'h00; length = 8'h00;
    fillMode = 1'b0; fillValue = 8'h00; pokeEn = 1'b0; pokeAddr = 8'h00; pokeData = 8'h00;
    test_reset();
    test_copy();
    test_zero_length();
    test_wrap();
    test_mid_reset();
    test_ignore_start();
    test_fill();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
